// File: rtl/win_vote_pkg.sv
// Shared types, reset constants and round-robin helper for the windowed
// w-vote arbiter.
package win_vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_WIN    = 3;
    localparam int DEF_TARGET = 2;
    localparam int MAX_CH     = 8;

    // First set bit of req at or after ptr, searching circularly over nch
    // channels. Walking downward lets the closest candidate overwrite the rest.
    function automatic int rr_next(input logic [MAX_CH-1:0] req,
                                   input int ptr,
                                   input int nch);
        int sel;
        int idx;
        sel = ptr;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < nch) begin
                idx = (ptr + i) % nch;
                if (req[3'(idx)]) sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/win_vote_engine.sv
// Window datapath: counts 1s on the selected w line and tracks how many
// samples of the current window have been taken.
module win_vote_engine #(
    parameter int WIN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [WIN_W-1:0] win,
    input  logic [WIN_W-1:0] tgt,
    output logic             last,
    output logic             hit
);

    logic [WIN_W-1:0] count_q, count_d;
    logic [WIN_W-1:0] samp_q, samp_d;

    always_comb begin
        count_d = count_q;
        samp_d  = samp_q;
        if (clr) begin
            count_d = '0;
            samp_d  = '0;
        end else if (en) begin
            count_d = count_q + WIN_W'(bit_in);
            samp_d  = samp_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            samp_q  <= '0;
        end else begin
            count_q <= count_d;
            samp_q  <= samp_d;
        end
    end

    // The sample taken this cycle is the final one of the window.
    assign last = (samp_q + WIN_W'(1)) == win;
    assign hit  = (count_q == tgt);

endmodule

// File: rtl/window_vote_arbiter.sv
// Round-robin arbiter sharing one windowed w-vote engine among NCH channels;
// sequences IDLE -> RUN (win_reg cycles) -> REPORT and pulses done per window.
module window_vote_arbiter
    import win_vote_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIN_W = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIN_W-1:0] cfg_win,
    input  logic [WIN_W-1:0] cfg_target,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   w,
    output logic [NCH-1:0]   grant,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic             z
);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  cur_q, cur_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIN_W-1:0] win_reg_q, win_reg_d;
    logic [WIN_W-1:0] tgt_reg_q, tgt_reg_d;

    logic            eng_clr, eng_en, eng_last, eng_hit;
    logic [ID_W-1:0] pick, cur_inc;

    assign pick    = ID_W'(rr_next(MAX_CH'(req), int'(rr_ptr_q), NCH));
    assign cur_inc = (cur_q == ID_W'(NCH - 1)) ? '0 : cur_q + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rr_ptr_d  = rr_ptr_q;
        win_reg_d = win_reg_q;
        tgt_reg_d = tgt_reg_q;
        eng_clr   = 1'b0;
        eng_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // A config cycle suppresses arbitration even with requests pending.
                if (cfg_we) begin
                    if (cfg_win != '0) begin
                        win_reg_d = cfg_win;
                        tgt_reg_d = cfg_target;
                    end
                end else if (req != '0) begin
                    cur_d   = pick;
                    eng_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!req[cur_q]) begin
                    rr_ptr_d = cur_inc;
                    state_d  = IDLE;
                end else begin
                    eng_en = 1'b1;
                    if (eng_last) state_d = REPORT;
                end
            end
            REPORT: begin
                rr_ptr_d = cur_inc;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rr_ptr_q  <= '0;
            win_reg_q <= WIN_W'(DEF_WIN);
            tgt_reg_q <= WIN_W'(DEF_TARGET);
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rr_ptr_q  <= rr_ptr_d;
            win_reg_q <= win_reg_d;
            tgt_reg_q <= tgt_reg_d;
        end
    end

    win_vote_engine #(.WIN_W(WIN_W)) u_engine (
        .clk    (clk),
        .reset  (reset),
        .clr    (eng_clr),
        .en     (eng_en),
        .bit_in (w[cur_q]),
        .win    (win_reg_q),
        .tgt    (tgt_reg_q),
        .last   (eng_last),
        .hit    (eng_hit)
    );

    always_comb begin
        grant = '0;
        if (state_q == RUN) grant[cur_q] = 1'b1;
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == REPORT);
    assign done_id = done ? cur_q : '0;
    assign z       = done & eng_hit;

endmodule
